sample_scheduler: RTL and testbench
===================================

# sample_scheduler

Sequences sample captures for the sampler front end. On a start command it waits a fixed settle interval, then issues a programmable number of sample requests at a programmable period, derived by dividing the system clock. Each request is handed to the capture datapath with a req/ack handshake. The block sits between the host/config logic and the capture datapath, and replaces free-running local-clock strobes with a counted, abortable burst.

## Interface
- DIV_W, 16: width of the sample period field, in clk cycles.
- CNT_W, 8: width of the sample count field and of the sample index.
- SETTLE_CYCLES, 16: number of clk cycles spent in SETTLE before the first request; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst start command; sampled only in IDLE.
- abort  in  1  burst abort command; effective in any state other than IDLE.
- cfg_period  in  DIV_W  cycles between sample ticks; latched on accepted start.
- cfg_count  in  CNT_W  number of samples in the burst; latched on accepted start.
- sample_ack  in  1  capture datapath has taken the current sample.
- sample_req  out  1  sample request, held high until acked.
- sample_idx  out  CNT_W  index of the outstanding or next sample (0-based).
- busy  out  1  high in SETTLE and RUN.
- done  out  1  one-cycle pulse when a burst completes normally.
- overrun  out  1  sticky flag: a tick arrived while a request was still outstanding.

## Operation
- States: IDLE, SETTLE, RUN, DONE.
- IDLE
  - start=1 latches cfg_period, cfg_count, and clears sample_idx and overrun.
  - Latched period P = max(cfg_period, 2); period values 0 and 1 clamp to 2.
  - cfg_count=0 goes directly to DONE. Any other count goes to SETTLE with the settle counter set to SETTLE_CYCLES-1.
- SETTLE
  - The settle counter decrements each cycle.
  - When the counter reaches 0: go to RUN, set sample_req=1, and load the period counter with P-1.
- RUN
  - The period counter decrements each cycle. At 0 it reloads P-1 and generates a tick.
  - A handshake completes when sample_req=1 and sample_ack=1 at a clock edge. On completion, sample_idx increments and sample_req drops.
  - A tick with no outstanding request (including one completing at the same edge) raises sample_req. If a completion and a tick coincide, sample_req stays high and sample_idx advances.
  - A tick with a request outstanding and no ack sets overrun. That tick is dropped; sample_idx and sample_req are unchanged.
  - When the completion count equals the latched count: go to DONE and drop sample_req. A coinciding tick is ignored.
- DONE: done=1 for this one cycle, then return to IDLE.
- abort=1 in SETTLE, RUN, or DONE: next state is IDLE and sample_req=0. done does not pulse (if already in DONE, the pulse still occurs in that cycle). sample_idx and overrun hold their values.
- start while not in IDLE is ignored. cfg_* changes after start have no effect.
- sample_ack while sample_req=0 is ignored.
- All counters are unsigned. sample_idx never wraps within a burst because it is bounded by the count.

## Timing
- Reset values: state=IDLE; sample_req=0, sample_idx=0, busy=0, done=0, overrun=0; all counters 0.
- Reset asserted mid-burst returns to IDLE immediately and asynchronously, with all outputs at their reset values.
- Let T be the edge at which start is sampled.
  - busy rises after T. SETTLE occupies cycles T+1 through T+SETTLE_CYCLES.
  - The first sample_req rises at cycle T+SETTLE_CYCLES+1. Subsequent ticks raise it every P cycles.
- Request drops in the cycle after the ack edge. Minimum req pulse is 1 cycle (ack already high).
- done is asserted in the cycle after the final ack edge. busy is low in that cycle. IDLE follows one cycle later, and start is accepted from then on.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- SETTLE_CYCLES=4, P=10, count=3, ack 2 cycles after each req rise, start sampled at cycle 0 -> req rises at cycles 5, 15, 25; sample_idx goes 0→1→2→3; done=1 at cycle 28; busy high cycles 1–27; overrun=0.
- Same configuration, no ack ever -> req held high from cycle 5; overrun=1 from cycle 15; sample_idx stays 0; abort at cycle 30 -> req=0 and IDLE at cycle 31; done never pulses.
- cfg_period=0 and cfg_period=1 -> ticks every 2 cycles. cfg_count=0 -> done pulse at cycle 1 with busy and req never high.
- Ack held constantly high, P=2, count=4 -> req high for 1 cycle per sample; 4 completions; done exactly once; a new start is accepted 2 cycles after done.
- Tick coinciding with an ack edge -> req stays high, sample_idx increments, no overrun. start pulsed during RUN and cfg_* changed mid-burst -> no effect.
- rst_n low mid-RUN -> all outputs 0 immediately. After release, a start runs a clean burst with overrun cleared.

Source files
------------

// File: rtl/sample_scheduler.sv
// Burst sample sequencer: settle delay after start, then a counted series of
// req/ack sample requests paced by a clamped clock divider. Abortable at any time.
module sample_scheduler #(
    parameter int DIV_W         = 16,
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             sample_ack,
    output logic             sample_req,
    output logic [CNT_W-1:0] sample_idx,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    logic [DIV_W-1:0] per_cnt;
    logic [DIV_W-1:0] per_m1;
    logic [CNT_W-1:0] count_q;

    logic             tick;
    logic             complete;
    logic             last;
    logic [CNT_W-1:0] idx_inc;

    // Reload value for the period counter; periods below 2 clamp to 2.
    function automatic logic [DIV_W-1:0] period_m1(input logic [DIV_W-1:0] p);
        return (p < DIV_W'(2)) ? DIV_W'(1) : p - DIV_W'(1);
    endfunction

    assign tick     = (per_cnt == '0);
    assign complete = sample_req && sample_ack;
    assign idx_inc  = sample_idx + 1'b1;
    assign last     = complete && (idx_inc == count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            per_cnt    <= '0;
            per_m1     <= '0;
            count_q    <= '0;
            sample_req <= 1'b0;
            sample_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        per_m1     <= period_m1(cfg_period);
                        count_q    <= cfg_count;
                        sample_idx <= '0;
                        overrun    <= 1'b0;
                        if (cfg_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                            busy       <= 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        sample_req <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state      <= S_RUN;
                        sample_req <= 1'b1;
                        per_cnt    <= per_m1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        sample_req <= 1'b0;
                    end else begin
                        per_cnt <= tick ? per_m1 : per_cnt - 1'b1;
                        if (last) begin
                            // Final completion wins over any coinciding tick.
                            state      <= S_DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            sample_req <= 1'b0;
                            sample_idx <= idx_inc;
                        end else begin
                            if (complete) begin
                                sample_idx <= idx_inc;
                            end
                            if (tick) begin
                                if (sample_req && !complete) begin
                                    overrun <= 1'b1;
                                end else begin
                                    sample_req <= 1'b1;
                                end
                            end else if (complete) begin
                                sample_req <= 1'b0;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: time-based reference model checked every cycle,
// plus directed bursts with hand-computed event cycles.
module tb_sample_scheduler;

    localparam int DIV_W  = 16;
    localparam int CNT_W  = 8;
    localparam int SETTLE = 4;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic             sample_ack = 1'b0;
    logic [DIV_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_count  = '0;
    logic             sample_req;
    logic [CNT_W-1:0] sample_idx;
    logic             busy;
    logic             done;
    logic             overrun;

    sample_scheduler #(
        .DIV_W        (DIV_W),
        .CNT_W        (CNT_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_period(cfg_period),
        .cfg_count (cfg_count),
        .sample_ack(sample_ack),
        .sample_req(sample_req),
        .sample_idx(sample_idx),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase boundaries and ticks derived from absolute edge times.
    int m_state = 0;  // 0 idle, 1 settle, 2 run, 3 done
    int m_e     = 0;
    int m_T     = 0;
    int m_P     = 2;
    int m_cnt   = 0;
    int m_req   = 0;
    int m_idx   = 0;
    int m_busy  = 0;
    int m_done  = 0;
    int m_ovr   = 0;

    initial begin : model
        int  since;
        bit  m_tick;
        bit  m_comp;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_req = 0; m_idx = 0; m_busy = 0; m_done = 0; m_ovr = 0;
            end else begin
                m_e++;
                m_done = 0;
                case (m_state)
                    0: if (start) begin
                        m_T   = m_e;
                        m_P   = (cfg_period < 2) ? 2 : int'(cfg_period);
                        m_cnt = int'(cfg_count);
                        m_idx = 0;
                        m_ovr = 0;
                        if (m_cnt == 0) begin
                            m_state = 3; m_done = 1;
                        end else begin
                            m_state = 1; m_busy = 1;
                        end
                    end
                    1: if (abort) begin
                        m_state = 0; m_req = 0; m_busy = 0;
                    end else if (m_e == m_T + SETTLE) begin
                        m_state = 2; m_req = 1;
                    end
                    2: if (abort) begin
                        m_state = 0; m_req = 0; m_busy = 0;
                    end else begin
                        since  = m_e - m_T - SETTLE;
                        m_tick = (since % m_P) == 0;
                        m_comp = (m_req == 1) && sample_ack;
                        if (m_comp) m_idx++;
                        if (m_comp && m_idx == m_cnt) begin
                            m_state = 3; m_done = 1; m_busy = 0; m_req = 0;
                        end else if (m_tick) begin
                            if (m_req == 1 && !m_comp) m_ovr = 1;
                            else m_req = 1;
                        end else if (m_comp) begin
                            m_req = 0;
                        end
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("req",     int'(sample_req), m_req);
            check("idx",     int'(sample_idx), m_idx);
            check("busy",    int'(busy),       m_busy);
            check("done",    int'(done),       m_done);
            check("overrun", int'(overrun),    m_ovr);
        end
    end

    // Directed stimulus knobs and per-cycle records (cycle 1 = first cycle after start edge).
    int  cyc;
    int  ack_q[$];
    bit  ack_const   = 1'b0;
    int  abort_at    = -1;
    int  start_from  = -1;
    int  start_to    = -1;
    int  cfg_chg_at  = -1;
    int  rec_req[0:63];
    int  rec_idx[0:63];
    int  rec_busy[0:63];
    int  rec_done[0:63];
    int  rec_ovr[0:63];
    int  rise_q[$];
    int  done_q[$];
    int  busy_first;
    int  busy_last;
    int  n_req_hi;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1;
    endfunction

    function automatic int first_done();
        return (done_q.size() > 0) ? done_q[0] : -1;
    endfunction

    task automatic run_burst(input int period, input int count, input int ncyc);
        bit hit;
        for (int i = 0; i < 64; i++) begin
            rec_req[i] = 0; rec_idx[i] = 0; rec_busy[i] = 0; rec_done[i] = 0; rec_ovr[i] = 0;
        end
        rise_q.delete();
        done_q.delete();
        busy_first = -1;
        busy_last  = -1;
        n_req_hi   = 0;
        cfg_period = DIV_W'(period);
        cfg_count  = CNT_W'(count);
        start      = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        while (cyc <= ncyc) begin
            rec_req[cyc]  = int'(sample_req);
            rec_idx[cyc]  = int'(sample_idx);
            rec_busy[cyc] = int'(busy);
            rec_done[cyc] = int'(done);
            rec_ovr[cyc]  = int'(overrun);
            if (sample_req && rec_req[cyc-1] == 0) rise_q.push_back(cyc);
            if (sample_req) n_req_hi++;
            if (done) done_q.push_back(cyc);
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            hit = 1'b0;
            foreach (ack_q[j]) if (ack_q[j] == cyc) hit = 1'b1;
            sample_ack = ack_const || hit;
            abort      = (cyc == abort_at);
            start      = (cyc >= start_from) && (cyc <= start_to);
            if (cyc == cfg_chg_at) begin
                cfg_period = DIV_W'(3);
                cfg_count  = CNT_W'(1);
            end
            step();
            cyc++;
        end
        sample_ack = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
    endtask

    initial begin : stim
        repeat (3) step();
        check("rst_req",  int'(sample_req), 0);
        check("rst_idx",  int'(sample_idx), 0);
        check("rst_busy", int'(busy),       0);
        check("rst_done", int'(done),       0);
        check("rst_ovr",  int'(overrun),    0);
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal burst: P=10, count=3, ack two cycles after each request.
        ack_q = '{7, 17, 27};
        run_burst(10, 3, 32);
        check("s1_nrise",  rise_q.size(), 3);
        check("s1_rise0",  rise_at(0), 5);
        check("s1_rise1",  rise_at(1), 15);
        check("s1_rise2",  rise_at(2), 25);
        check("s1_done",   first_done(), 28);
        check("s1_ndone",  done_q.size(), 1);
        check("s1_bfirst", busy_first, 1);
        check("s1_blast",  busy_last, 27);
        check("s1_idx7",   rec_idx[7], 0);
        check("s1_idx8",   rec_idx[8], 1);
        check("s1_req8",   rec_req[8], 0);
        check("s1_idx18",  rec_idx[18], 2);
        check("s1_idx28",  rec_idx[28], 3);
        check("s1_ovr28",  rec_ovr[28], 0);
        repeat (2) step();

        // No ack: overrun on the first dropped tick, then abort.
        ack_q.delete();
        abort_at = 30;
        run_burst(10, 3, 33);
        check("s2_req5",   rec_req[5], 1);
        check("s2_ovr14",  rec_ovr[14], 0);
        check("s2_ovr15",  rec_ovr[15], 1);
        check("s2_idx30",  rec_idx[30], 0);
        check("s2_req30",  rec_req[30], 1);
        check("s2_req31",  rec_req[31], 0);
        check("s2_busy31", rec_busy[31], 0);
        check("s2_ovr31",  rec_ovr[31], 1);
        check("s2_ndone",  done_q.size(), 0);
        abort_at = -1;
        repeat (2) step();

        // Period clamp: 0 and 1 both behave as 2.
        ack_const = 1'b1;
        run_burst(0, 2, 10);
        check("p0_rise0", rise_at(0), 5);
        check("p0_rise1", rise_at(1), 7);
        check("p0_done",  first_done(), 8);
        repeat (2) step();
        run_burst(1, 2, 10);
        check("p1_rise0", rise_at(0), 5);
        check("p1_rise1", rise_at(1), 7);
        check("p1_done",  first_done(), 8);
        repeat (2) step();

        // Zero count: immediate done, never busy.
        ack_const = 1'b0;
        run_burst(10, 0, 4);
        check("c0_done1", rec_done[1], 1);
        check("c0_done2", rec_done[2], 0);
        check("c0_ndone", done_q.size(), 1);
        check("c0_busy",  busy_first, -1);
        check("c0_nrise", rise_q.size(), 0);
        repeat (2) step();

        // Ack held high, P=2, count=4; start held across DONE and IDLE.
        ack_const  = 1'b1;
        start_from = 12;
        start_to   = 13;
        run_burst(2, 4, 14);
        check("a_nrise",  rise_q.size(), 4);
        check("a_reqhi",  n_req_hi, 4);
        check("a_rise3",  rise_at(3), 11);
        check("a_done",   first_done(), 12);
        check("a_ndone",  done_q.size(), 1);
        check("a_idx12",  rec_idx[12], 4);
        check("a_busy13", rec_busy[13], 0);
        check("a_busy14", rec_busy[14], 1);
        ack_const  = 1'b0;
        start_from = -1;
        start_to   = -1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("a_abort_busy", int'(busy), 0);
        repeat (2) step();

        // Tick coinciding with ack; start and cfg changes mid-burst ignored.
        ack_q      = '{14, 15, 25};
        start_from = 8;
        start_to   = 8;
        cfg_chg_at = 2;
        run_burst(10, 3, 30);
        check("co_req15", rec_req[15], 1);
        check("co_idx15", rec_idx[15], 1);
        check("co_ovr15", rec_ovr[15], 0);
        check("co_req16", rec_req[16], 0);
        check("co_idx16", rec_idx[16], 2);
        check("co_nrise", rise_q.size(), 2);
        check("co_rise1", rise_at(1), 25);
        check("co_done",  first_done(), 26);
        check("co_ovr26", rec_ovr[26], 0);
        start_from = -1;
        start_to   = -1;
        cfg_chg_at = -1;
        repeat (2) step();

        // Asynchronous reset mid-RUN, then a clean burst.
        ack_q.delete();
        run_burst(10, 3, 16);
        check("r_ovr16", rec_ovr[16], 1);
        check("r_req16", rec_req[16], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_req",  int'(sample_req), 0);
        check("r_idx",  int'(sample_idx), 0);
        check("r_busy", int'(busy),       0);
        check("r_done", int'(done),       0);
        check("r_ovr",  int'(overrun),    0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        ack_q = '{7, 17, 27};
        run_burst(10, 3, 30);
        check("r2_ovr5",  rec_ovr[5], 0);
        check("r2_rise0", rise_at(0), 5);
        check("r2_rise2", rise_at(2), 25);
        check("r2_done",  first_done(), 28);
        check("r2_ovr28", rec_ovr[28], 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
